// File: rtl/aes_block_packer.sv
// aes_block_packer: packs a 32-bit big-endian word stream into 128-bit AES
// blocks, zero-pads the final partial block from the programmed byte length
// and flags the last block of the job.
module aes_block_packer #(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned BLOCK_W = 128,
    parameter int unsigned LEN_W   = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               start_i,
    input  logic [LEN_W-1:0]   data_size_i,
    input  logic [WORD_W-1:0]  in_data_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic [BLOCK_W-1:0] blk_data_o,
    output logic               blk_valid_o,
    input  logic               blk_ready_i,
    output logic               blk_last_o,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FILL    = 2'd1,
        S_PRESENT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [BLOCK_W-1:0] r_blk;
    logic [1:0]         r_idx;
    logic [1:0]         r_rem;
    logic [LEN_W:0]     r_words_left;
    logic [LEN_W:0]     r_blocks_left;

    logic               w_clr;
    logic               w_accept;
    logic               w_last_word;
    logic               w_last_block;
    logic [LEN_W:0]     w_size_ext;
    logic [LEN_W:0]     w_words_calc;
    logic [LEN_W:0]     w_blocks_calc;
    logic [WORD_W-1:0]  w_word;

    assign w_clr         = rst_i | clear_i;
    assign w_accept      = (r_state == S_FILL) & in_valid_i;
    assign w_last_word   = (r_words_left == (LEN_W+1)'(1));
    assign w_last_block  = (r_blocks_left == (LEN_W+1)'(1));
    // One extra bit so that a length near 2^LEN_W cannot wrap when rounding up.
    assign w_size_ext    = {1'b0, data_size_i};
    assign w_words_calc  = (w_size_ext + (LEN_W+1)'(3)) >> 2;
    assign w_blocks_calc = (w_size_ext + (LEN_W+1)'(15)) >> 4;

    // Zero the trailing bytes of the job's final word when the length is not word aligned.
    always_comb begin
        w_word = in_data_i;
        if (w_last_word) begin
            case (r_rem)
                2'd1:    w_word = {in_data_i[31:24], 24'h0};
                2'd2:    w_word = {in_data_i[31:16], 16'h0};
                2'd3:    w_word = {in_data_i[31:8], 8'h0};
                default: w_word = in_data_i;
            endcase
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_next      = r_state;
        in_ready_o  = 1'b0;
        blk_valid_o = 1'b0;
        blk_last_o  = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    w_next = (data_size_i == '0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                in_ready_o = 1'b1;
                if (w_accept && ((r_idx == 2'd3) || w_last_word)) begin
                    w_next = S_PRESENT;
                end
            end
            S_PRESENT: begin
                blk_valid_o = 1'b1;
                blk_last_o  = w_last_block;
                if (blk_ready_i) begin
                    w_next = w_last_block ? S_DONE : S_FILL;
                end
            end
            S_DONE: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register; reset and soft clear both override any pending transition.
    always_ff @(posedge clk_i) begin
        if (w_clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Block register, slot index and job counters.
    always_ff @(posedge clk_i) begin
        if (w_clr) begin
            r_blk         <= '0;
            r_idx         <= '0;
            r_rem         <= '0;
            r_words_left  <= '0;
            r_blocks_left <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_words_left  <= w_words_calc;
                        r_blocks_left <= w_blocks_calc;
                        r_rem         <= data_size_i[1:0];
                        r_blk         <= '0;
                        r_idx         <= '0;
                    end
                end
                S_FILL: begin
                    if (w_accept) begin
                        case (r_idx)
                            2'd0:    r_blk[127:96] <= w_word;
                            2'd1:    r_blk[95:64]  <= w_word;
                            2'd2:    r_blk[63:32]  <= w_word;
                            default: r_blk[31:0]   <= w_word;
                        endcase
                        r_words_left <= r_words_left - (LEN_W+1)'(1);
                        r_idx        <= r_idx + 2'd1;
                    end
                end
                S_PRESENT: begin
                    if (blk_ready_i) begin
                        r_blocks_left <= r_blocks_left - (LEN_W+1)'(1);
                        if (!w_last_block) begin
                            r_blk <= '0;
                            r_idx <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign blk_data_o = r_blk;

endmodule

// File: tb/tb_aes_block_packer.sv
// Scoreboard bench for aes_block_packer: expected blocks are queued before each
// job; a negedge monitor pops and compares on every block handshake.
module tb_aes_block_packer;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         clear_i = 1'b0;
    logic         start_i = 1'b0;
    logic [31:0]  data_size_i = '0;
    logic [31:0]  in_data_i = '0;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [127:0] blk_data_o;
    logic         blk_valid_o;
    logic         blk_ready_i = 1'b1;
    logic         blk_last_o;
    logic         busy_o;
    logic         done_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [127:0] d;
        logic         l;
    } exp_t;
    exp_t sb[$];

    aes_block_packer #(.WORD_W(32), .BLOCK_W(128), .LEN_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
        .data_size_i(data_size_i), .in_data_i(in_data_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .blk_data_o(blk_data_o), .blk_valid_o(blk_valid_o),
        .blk_ready_i(blk_ready_i), .blk_last_o(blk_last_o), .busy_o(busy_o),
        .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [127:0] d, input logic l);
        exp_t e;
        e.d = d;
        e.l = l;
        sb.push_back(e);
    endtask

    // Monitor: compare every block handshake against the scoreboard.
    always @(negedge clk_i) begin
        if (!rst_i && !clear_i && blk_valid_o && blk_ready_i) begin
            if (sb.size() == 0) begin
                chk("unexpected_blk", blk_data_o, '0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("blk_data", blk_data_o, e.d);
                chk("blk_last", 128'(blk_last_o), 128'(e.l));
            end
        end
    end

    task automatic pulse_start(input logic [31:0] sz);
        @(posedge clk_i); #1;
        data_size_i = sz;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        bit ok;
        ok = 0;
        in_valid_i = 1'b1;
        in_data_i = w;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i);
            if (in_ready_o) begin
                @(posedge clk_i); #1;
                ok = 1;
                break;
            end
        end
        in_valid_i = 1'b0;
        if (!ok) chk("word_timeout", 128'(0), 128'(1));
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                seen = 1;
                break;
            end
        end
        chk("done_seen", 128'(seen), 128'(1));
        @(negedge clk_i);
        chk("done_one_cycle", 128'(done_o), 128'(0));
        chk("idle_after_done", 128'(busy_o), 128'(0));
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_data"}, blk_data_o, '0);
        chk({name, "_ctl"}, 128'({in_ready_o, blk_valid_o, blk_last_o, busy_o, done_o}), 128'(0));
    endtask

    task automatic abort_test(input bit use_rst);
        pulse_start(32'd16);
        send_word(32'hDEADBEEF);
        send_word(32'hCAFEF00D);
        in_valid_i = 1'b1;
        in_data_i = 32'h55555555;
        if (use_rst) rst_i = 1'b1; else clear_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        clear_i = 1'b0;
        in_valid_i = 1'b0;
        chk_all_zero(use_rst ? "after_rst" : "after_clear");
        push(128'h01020304_05060708_090A0B0C_0D0E0F10, 1'b1);
        pulse_start(32'd16);
        send_word(32'h01020304);
        send_word(32'h05060708);
        send_word(32'h090A0B0C);
        send_word(32'h0D0E0F10);
        wait_done();
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        chk_all_zero("reset");
        rst_i = 1'b0;

        // Single full block.
        push(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1);
        pulse_start(32'd16);
        send_word(32'h00112233);
        send_word(32'h44556677);
        send_word(32'h8899AABB);
        send_word(32'hCCDDEEFF);
        #1;
        chk("present_valid", 128'(blk_valid_o), 128'(1));
        wait_done();

        // Two blocks, second holds one word.
        push(128'h10000001_20000002_30000003_40000004, 1'b0);
        push(128'h50000005_00000000_00000000_00000000, 1'b1);
        pulse_start(32'd20);
        send_word(32'h10000001);
        send_word(32'h20000002);
        send_word(32'h30000003);
        send_word(32'h40000004);
        send_word(32'h50000005);
        wait_done();

        // Partial last word padding.
        push(128'hAABBCCDD_11220000_00000000_00000000, 1'b1);
        pulse_start(32'd6);
        send_word(32'hAABBCCDD);
        send_word(32'h11223344);
        wait_done();

        // Backpressure in PRESENT.
        push(128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3, 1'b0);
        push(128'hE4E4E4E4_F5F5F5F5_06060606_17171717, 1'b1);
        blk_ready_i = 1'b0;
        pulse_start(32'd32);
        send_word(32'hA0A0A0A0);
        send_word(32'hB1B1B1B1);
        send_word(32'hC2C2C2C2);
        send_word(32'hD3D3D3D3);
        in_valid_i = 1'b1;
        in_data_i = 32'hE4E4E4E4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("stall_data", blk_data_o, 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3);
            chk("stall_ctl", 128'({blk_valid_o, blk_last_o, in_ready_o}), 128'(3'b100));
        end
        @(posedge clk_i); #1;
        blk_ready_i = 1'b1;
        send_word(32'hE4E4E4E4);
        send_word(32'hF5F5F5F5);
        send_word(32'h06060606);
        send_word(32'h17171717);
        wait_done();

        // Zero length, then a start during DONE that must be ignored.
        pulse_start(32'd0);
        chk("zero_done", 128'({done_o, blk_valid_o}), 128'(2'b10));
        data_size_i = 32'd16;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        chk("start_in_done_ignored", 128'({busy_o, done_o}), 128'(0));

        // Abort mid-block via clear, then via reset.
        abort_test(1'b0);
        abort_test(1'b1);

        chk("sb_drained", 128'(sb.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
